// File: rtl/irq_lat_pkg.sv
// Shared types, defaults and helpers
// for the IRQ latency tap.
package irq_lat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PEND = 2'd2
  } ch_state_e;

  localparam int TAP_LEVEL  = 0;
  localparam int TAP_TOGGLE = 1;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_PER_W  = 32;
  localparam int DEF_LAT_W  = 24;
  localparam int DEF_CNT_W  = 16;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] vmax
  );
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

endpackage

// File: rtl/irq_latency_tap_if.sv
// CSR-side bus of the IRQ latency tap:
// controls in, flags and statistics out.
interface irq_latency_tap_if
  import irq_lat_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PER_W  = DEF_PER_W,
  parameter int LAT_W  = DEF_LAT_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*PER_W-1:0] period;
  logic [NUM_CH-1:0]       ack;
  logic                    stats_clear;
  logic                    irq;
  logic [NUM_CH-1:0]       irq_flag;
  logic [NUM_CH-1:0]       tap;
  logic [NUM_CH*LAT_W-1:0] last_lat;
  logic [NUM_CH*LAT_W-1:0] min_lat;
  logic [NUM_CH*LAT_W-1:0] max_lat;
  logic [NUM_CH*CNT_W-1:0] sample_cnt;
  logic [NUM_CH*CNT_W-1:0] miss_cnt;

  modport master (
    output enable, period, ack, stats_clear,
    input  irq, irq_flag, tap,
    input  last_lat, min_lat, max_lat,
    input  sample_cnt, miss_cnt
  );

  modport slave (
    input  enable, period, ack, stats_clear,
    output irq, irq_flag, tap,
    output last_lat, min_lat, max_lat,
    output sample_cnt, miss_cnt
  );

endinterface

// File: rtl/irq_lat_channel.sv
// One IRQ channel: period timer, pending
// flag, latency counter and statistics.
module irq_lat_channel
  import irq_lat_pkg::*;
#(
  parameter int PER_W    = DEF_PER_W,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TAP_MODE = TAP_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             ack_i,
  input  logic             clear_i,
  output logic             flag_o,
  output logic             tap_o,
  output logic [LAT_W-1:0] last_o,
  output logic [LAT_W-1:0] min_o,
  output logic [LAT_W-1:0] max_o,
  output logic [CNT_W-1:0] smp_o,
  output logic [CNT_W-1:0] miss_o
);

  localparam logic [31:0] LAT_MAX =
    32'((64'd1 << LAT_W) - 64'd1);
  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << CNT_W) - 64'd1);

  ch_state_e        state_q, state_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             flag_q, flag_d;
  logic             tap_q, tap_d;
  logic [LAT_W-1:0] last_q, last_d;
  logic [LAT_W-1:0] min_q, min_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic [PER_W-1:0] reload;
  logic [PER_W-1:0] tmr_run;
  logic             expire;
  logic             rearm;

  // A zero period parks the timer at 0 so
  // a later non-zero period fires at once.
  assign reload = (period_i == '0) ? '0
                : period_i - PER_W'(1);
  assign expire = (timer_q == '0)
               && (period_i != '0);
  assign tmr_run = expire ? reload
                 : (timer_q != '0)
                 ? timer_q - PER_W'(1)
                 : timer_q;

  // Next state, timer, latency and stats.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lat_d   = lat_q;
    flag_d  = flag_q;
    last_d  = last_q;
    min_d   = min_q;
    max_d   = max_q;
    smp_d   = smp_q;
    miss_d  = miss_q;
    rearm   = 1'b0;

    if (clear_i) begin
      last_d = '0;
      min_d  = '1;
      max_d  = '0;
      smp_d  = '0;
      miss_d = '0;
    end

    if (!enable_i) begin
      state_d = ST_IDLE;
      timer_d = '0;
      lat_d   = '0;
      flag_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_d = reload;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          timer_d = tmr_run;
          if (expire) begin
            flag_d  = 1'b1;
            lat_d   = LAT_W'(1);
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          timer_d = tmr_run;
          lat_d = LAT_W'(sat_inc(
            32'(lat_q), LAT_MAX));
          if (ack_i) begin
            last_d = lat_q;
            if (lat_q < min_d) min_d = lat_q;
            if (lat_q > max_d) max_d = lat_q;
            smp_d = CNT_W'(sat_inc(
              32'(smp_d), CNT_MAX));
            if (expire) begin
              rearm = 1'b1;
              lat_d = LAT_W'(1);
            end else begin
              flag_d  = 1'b0;
              lat_d   = '0;
              state_d = ST_WAIT;
            end
          end else if (expire) begin
            miss_d = CNT_W'(sat_inc(
              32'(miss_d), CNT_MAX));
          end
        end
        default: begin
          state_d = ST_IDLE;
          flag_d  = 1'b0;
          timer_d = '0;
          lat_d   = '0;
        end
      endcase
    end

    if (TAP_MODE == TAP_TOGGLE)
      tap_d = tap_q
            ^ ((flag_d & ~flag_q) | rearm);
    else
      tap_d = flag_d;
  end

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      lat_q   <= '0;
      flag_q  <= 1'b0;
      tap_q   <= 1'b0;
      last_q  <= '0;
      min_q   <= '1;
      max_q   <= '0;
      smp_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lat_q   <= lat_d;
      flag_q  <= flag_d;
      tap_q   <= tap_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
      smp_q   <= smp_d;
      miss_q  <= miss_d;
    end
  end

  assign flag_o = flag_q;
  assign tap_o  = tap_q;
  assign last_o = last_q;
  assign min_o  = min_q;
  assign max_o  = max_q;
  assign smp_o  = smp_q;
  assign miss_o = miss_q;

endmodule

// File: rtl/irq_latency_tap.sv
// Multi-channel IRQ generator and latency
// meter; slices buses and ORs the flags.
module irq_latency_tap
  import irq_lat_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PER_W    = DEF_PER_W,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TAP_MODE = TAP_LEVEL
) (
  input logic clk,
  input logic reset,
  irq_latency_tap_if.slave bus
);

  logic [NUM_CH-1:0]       flag_w;
  logic [NUM_CH-1:0]       tap_w;
  logic [NUM_CH*LAT_W-1:0] last_w;
  logic [NUM_CH*LAT_W-1:0] min_w;
  logic [NUM_CH*LAT_W-1:0] max_w;
  logic [NUM_CH*CNT_W-1:0] smp_w;
  logic [NUM_CH*CNT_W-1:0] miss_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    irq_lat_channel #(
      .PER_W    (PER_W),
      .LAT_W    (LAT_W),
      .CNT_W    (CNT_W),
      .TAP_MODE (TAP_MODE)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable_i (bus.enable[i]),
      .period_i (bus.period[i*PER_W +: PER_W]),
      .ack_i    (bus.ack[i]),
      .clear_i  (bus.stats_clear),
      .flag_o   (flag_w[i]),
      .tap_o    (tap_w[i]),
      .last_o   (last_w[i*LAT_W +: LAT_W]),
      .min_o    (min_w[i*LAT_W +: LAT_W]),
      .max_o    (max_w[i*LAT_W +: LAT_W]),
      .smp_o    (smp_w[i*CNT_W +: CNT_W]),
      .miss_o   (miss_w[i*CNT_W +: CNT_W])
    );
  end

  assign bus.irq        = |flag_w;
  assign bus.irq_flag   = flag_w;
  assign bus.tap        = tap_w;
  assign bus.last_lat   = last_w;
  assign bus.min_lat    = min_w;
  assign bus.max_lat    = max_w;
  assign bus.sample_cnt = smp_w;
  assign bus.miss_cnt   = miss_w;

endmodule

// File: tb/tb_irq_latency_tap.sv
// Bench: two taps (24-bit level, 4-bit toggle)
// on shared stimulus against a timestamp model.
module tb_irq_latency_tap;

  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic [3:0] ack;
  logic       clr;
  logic [31:0] per [4];

  int n_cmp = 0;
  int n_bad = 0;

  irq_latency_tap_if #(
    .NUM_CH(4), .PER_W(32), .LAT_W(24), .CNT_W(16)
  ) bus_a ();
  irq_latency_tap_if #(
    .NUM_CH(4), .PER_W(32), .LAT_W(4), .CNT_W(16)
  ) bus_b ();

  assign bus_a.enable      = en;
  assign bus_a.ack         = ack;
  assign bus_a.stats_clear = clr;
  assign bus_a.period      = {per[3], per[2], per[1], per[0]};
  assign bus_b.enable      = en;
  assign bus_b.ack         = ack;
  assign bus_b.stats_clear = clr;
  assign bus_b.period      = {per[3], per[2], per[1], per[0]};

  irq_latency_tap #(
    .NUM_CH(4), .PER_W(32), .LAT_W(24),
    .CNT_W(16), .TAP_MODE(0)
  ) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a)
  );

  irq_latency_tap #(
    .NUM_CH(4), .PER_W(32), .LAT_W(4),
    .CNT_W(16), .TAP_MODE(1)
  ) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int d,
                       input int c, input longint got,
                       input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d ch%0d: got %0d expected %0d",
               nm, d, c, got, exp);
    end
  endtask

  // Model: absolute edge timestamps for the
  // next trigger and for the flag rise.
  longint lat_max [2] = '{64'hFFFFFF, 64'd15};
  int     tap_md  [2] = '{0, 1};
  longint n_edge = 0;
  bit     mvalid = 1'b0;
  bit     m_run  [2][4];
  bit     m_flag [2][4];
  bit     m_tap  [2][4];
  longint m_fire [2][4];
  longint m_fedge[2][4];
  longint m_last [2][4];
  longint m_min  [2][4];
  longint m_max  [2][4];
  longint m_smp  [2][4];
  longint m_miss [2][4];

  // Advance the model by one clock edge.
  always @(posedge clk) begin
    n_edge++;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        bit fire, cap, rearm, miss, rise;
        longint p, k;
        p = longint'(per[c]);
        fire = 1'b0; cap = 1'b0; rearm = 1'b0;
        miss = 1'b0; rise = 1'b0; k = 0;
        if (rst) begin
          m_run[d][c]  = 1'b0;
          m_flag[d][c] = 1'b0;
          m_tap[d][c]  = 1'b0;
          m_last[d][c] = 0;
          m_min[d][c]  = lat_max[d];
          m_max[d][c]  = 0;
          m_smp[d][c]  = 0;
          m_miss[d][c] = 0;
        end else begin
          if (!en[c]) begin
            m_run[d][c]  = 1'b0;
            m_flag[d][c] = 1'b0;
          end else if (!m_run[d][c]) begin
            m_run[d][c]  = 1'b1;
            m_fire[d][c] = n_edge + ((p == 0) ? 1 : p);
          end else begin
            fire = (n_edge >= m_fire[d][c]) && (p != 0);
            if (fire) m_fire[d][c] = n_edge + p;
            if (m_flag[d][c]) begin
              if (ack[c]) begin
                cap = 1'b1;
                k = n_edge - m_fedge[d][c];
                if (k > lat_max[d]) k = lat_max[d];
                if (fire) begin
                  rearm = 1'b1;
                  m_fedge[d][c] = n_edge;
                end else begin
                  m_flag[d][c] = 1'b0;
                end
              end else if (fire) begin
                miss = 1'b1;
              end
            end else if (fire) begin
              m_flag[d][c]  = 1'b1;
              m_fedge[d][c] = n_edge;
              rise = 1'b1;
            end
          end
          if (clr) begin
            m_last[d][c] = 0;
            m_min[d][c]  = lat_max[d];
            m_max[d][c]  = 0;
            m_smp[d][c]  = 0;
            m_miss[d][c] = 0;
          end
          if (cap) begin
            m_last[d][c] = k;
            if (k < m_min[d][c]) m_min[d][c] = k;
            if (k > m_max[d][c]) m_max[d][c] = k;
            if (m_smp[d][c] < 65535) m_smp[d][c]++;
          end
          if (miss && m_miss[d][c] < 65535) m_miss[d][c]++;
          if (tap_md[d] == 0) m_tap[d][c] = m_flag[d][c];
          else if (rise || rearm) m_tap[d][c] = ~m_tap[d][c];
        end
      end
    end
    mvalid = 1'b1;
  end

  // Compare both DUTs with the model.
  always @(negedge clk) begin
    if (mvalid) begin
      bit any_a, any_b;
      any_a = 1'b0; any_b = 1'b0;
      for (int c = 0; c < 4; c++) begin
        any_a |= m_flag[0][c];
        any_b |= m_flag[1][c];
        check("irq_flag", 0, c, longint'(bus_a.irq_flag[c]), longint'(m_flag[0][c]));
        check("irq_flag", 1, c, longint'(bus_b.irq_flag[c]), longint'(m_flag[1][c]));
        check("tap", 0, c, longint'(bus_a.tap[c]), longint'(m_tap[0][c]));
        check("tap", 1, c, longint'(bus_b.tap[c]), longint'(m_tap[1][c]));
        check("last_lat", 0, c, longint'(bus_a.last_lat[c*24 +: 24]), m_last[0][c]);
        check("last_lat", 1, c, longint'(bus_b.last_lat[c*4 +: 4]), m_last[1][c]);
        check("min_lat", 0, c, longint'(bus_a.min_lat[c*24 +: 24]), m_min[0][c]);
        check("min_lat", 1, c, longint'(bus_b.min_lat[c*4 +: 4]), m_min[1][c]);
        check("max_lat", 0, c, longint'(bus_a.max_lat[c*24 +: 24]), m_max[0][c]);
        check("max_lat", 1, c, longint'(bus_b.max_lat[c*4 +: 4]), m_max[1][c]);
        check("sample_cnt", 0, c, longint'(bus_a.sample_cnt[c*16 +: 16]), m_smp[0][c]);
        check("sample_cnt", 1, c, longint'(bus_b.sample_cnt[c*16 +: 16]), m_smp[1][c]);
        check("miss_cnt", 0, c, longint'(bus_a.miss_cnt[c*16 +: 16]), m_miss[0][c]);
        check("miss_cnt", 1, c, longint'(bus_b.miss_cnt[c*16 +: 16]), m_miss[1][c]);
      end
      check("irq", 0, 0, longint'(bus_a.irq), longint'(any_a));
      check("irq", 1, 0, longint'(bus_b.irq), longint'(any_b));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic lit(input string nm, input longint got,
                     input longint exp);
    check(nm, 0, 0, got, exp);
  endtask

  // Directed stimulus with literal anchors.
  initial begin
    rst = 1'b1; en = 4'h0; ack = 4'h0; clr = 1'b0;
    for (int c = 0; c < 4; c++) per[c] = 32'd0;
    cyc(3);
    lit("rst_flag", longint'(bus_a.irq_flag), 0);
    lit("rst_min", longint'(bus_a.min_lat[23:0]), 64'hFFFFFF);
    lit("rst_minb", longint'(bus_b.min_lat[3:0]), 15);
    lit("rst_irq", longint'(bus_a.irq), 0);

    rst = 1'b0; per[0] = 32'd10; en[0] = 1'b1;
    cyc(10);
    lit("t1_flag_pre", longint'(bus_a.irq_flag[0]), 0);
    cyc(1);
    lit("t1_flag_rise", longint'(bus_a.irq_flag[0]), 1);
    cyc(4);
    ack[0] = 1'b1;
    cyc(1);
    ack[0] = 1'b0;
    lit("t1_last", longint'(bus_a.last_lat[23:0]), 5);
    lit("t1_min", longint'(bus_a.min_lat[23:0]), 5);
    lit("t1_max", longint'(bus_a.max_lat[23:0]), 5);
    lit("t1_smp", longint'(bus_a.sample_cnt[15:0]), 1);
    lit("t1_flag_low", longint'(bus_a.irq_flag[0]), 0);
    lit("t1_tapb", longint'(bus_b.tap[0]), 1);

    cyc(5);
    lit("t2_flag", longint'(bus_a.irq_flag[0]), 1);
    cyc(35);
    lit("t2_miss", longint'(bus_a.miss_cnt[15:0]), 3);
    lit("t2_flag_held", longint'(bus_a.irq_flag[0]), 1);
    ack[0] = 1'b1;
    cyc(1);
    ack[0] = 1'b0;
    lit("t2_last", longint'(bus_a.last_lat[23:0]), 36);
    lit("t2_lastb_sat", longint'(bus_b.last_lat[3:0]), 15);
    lit("t2_max", longint'(bus_a.max_lat[23:0]), 36);
    lit("t2_smp", longint'(bus_a.sample_cnt[15:0]), 2);

    cyc(4);
    lit("t3_flag", longint'(bus_a.irq_flag[0]), 1);
    cyc(9);
    ack[0] = 1'b1;
    cyc(1);
    ack[0] = 1'b0;
    lit("t3_flag_kept", longint'(bus_a.irq_flag[0]), 1);
    lit("t3_last", longint'(bus_a.last_lat[23:0]), 10);
    lit("t3_smp", longint'(bus_a.sample_cnt[15:0]), 3);
    lit("t3_miss", longint'(bus_a.miss_cnt[15:0]), 3);
    lit("t3_tapa", longint'(bus_a.tap[0]), 1);
    lit("t3_tapb", longint'(bus_b.tap[0]), 0);

    cyc(6);
    en[0] = 1'b0;
    cyc(1);
    lit("t4_flag_drop", longint'(bus_a.irq_flag[0]), 0);
    lit("t4_smp", longint'(bus_a.sample_cnt[15:0]), 3);
    en[0] = 1'b1;
    cyc(10);
    lit("t4_flag_pre", longint'(bus_a.irq_flag[0]), 0);
    cyc(1);
    lit("t4_flag_rise", longint'(bus_a.irq_flag[0]), 1);
    ack[0] = 1'b1;
    cyc(1);
    ack[0] = 1'b0;
    lit("t4_last", longint'(bus_a.last_lat[23:0]), 1);
    lit("t4_min", longint'(bus_a.min_lat[23:0]), 1);

    cyc(9);
    lit("t5_flag", longint'(bus_a.irq_flag[0]), 1);
    cyc(3);
    ack[0] = 1'b1; clr = 1'b1;
    cyc(1);
    ack[0] = 1'b0; clr = 1'b0;
    lit("t5_last", longint'(bus_a.last_lat[23:0]), 4);
    lit("t5_min", longint'(bus_a.min_lat[23:0]), 4);
    lit("t5_max", longint'(bus_a.max_lat[23:0]), 4);
    lit("t5_smp", longint'(bus_a.sample_cnt[15:0]), 1);
    lit("t5_miss", longint'(bus_a.miss_cnt[15:0]), 0);

    en = 4'h0;
    cyc(1);
    per[0] = 32'd8; per[1] = 32'd13;
    per[2] = 32'd0; per[3] = 32'd21;
    en = 4'hF;
    for (int i = 0; i < 80; i++) begin
      ack[0] = (i % 7) == 6;
      ack[1] = (i % 17) == 16;
      ack[2] = (i % 5) == 4;
      ack[3] = (i % 25) == 24;
      cyc(1);
    end
    ack = 4'h0;
    lit("t6_flag2", longint'(bus_a.irq_flag[2]), 0);
    lit("t6_smp2", longint'(bus_a.sample_cnt[47:32]), 0);
    lit("t6_miss2", longint'(bus_a.miss_cnt[47:32]), 0);
    lit("t6_min2", longint'(bus_a.min_lat[71:48]), 64'hFFFFFF);

    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    lit("t7_flag", longint'(bus_a.irq_flag), 0);
    lit("t7_min", longint'(bus_a.min_lat[23:0]), 64'hFFFFFF);
    lit("t7_smp", longint'(bus_a.sample_cnt[15:0]), 0);
    lit("t7_tapb", longint'(bus_b.tap), 0);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
